regfile_debug_dumper: RTL and testbench

- Debug-unit stage that sits directly downstream of the register file's debug read port.
- On a start pulse it takes over the port (drives debug-enable and debug address), reads every architectural register in turn, and serializes each 32-bit value as bytes.
- Bytes go out through a valid/ready byte stream to the debug UART transmitter.
- Used by the PC-side debugger to snapshot the 32x32 register file.

---
 rtl/regfile_debug_dumper.sv | 117 +++++++++++
 tb/tb_regfile_debug_dumper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_dumper.sv
// Register-file debug dumper: takes over the debug read port on start
// and streams a header byte plus every register, MSB first, as bytes.
module regfile_debug_dumper #(
  parameter int          NUM_REGS = 32,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        dbg_on,
  output logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SET_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  // Six bits so the last index of a 32-entry dump is compared exactly.
  localparam logic [5:0] LAST = 6'(NUM_REGS - 1);

  state_t      state;
  logic [5:0]  reg_idx;
  logic [1:0]  byte_idx;
  // Remaining three bytes of the captured word; the top byte is
  // loaded straight into tx_data at capture time.
  logic [23:0] word;

  // Dump sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbg_on   <= 1'b0;
      dbg_addr <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      reg_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_HEADER;
            busy     <= 1'b1;
            dbg_on   <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= HEADER;
          end
        end
        S_HEADER: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_SET_ADDR;
          end
        end
        S_SET_ADDR: begin
          dbg_addr <= reg_idx[4:0];
          state    <= S_WAIT;
        end
        S_WAIT: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          word     <= dbg_data[23:0];
          tx_data  <= dbg_data[31:24];
          tx_valid <= 1'b1;
          byte_idx <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (byte_idx == 2'd3) begin
              tx_valid <= 1'b0;
              if (reg_idx == LAST) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                reg_idx <= reg_idx + 6'd1;
                state   <= S_SET_ADDR;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx_data  <= word[23:16];
              word     <= {word[15:0], 8'h00};
            end
          end
        end
        S_DONE: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          dbg_on   <= 1'b0;
          dbg_addr <= '0;
          reg_idx  <= '0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Bench for regfile_debug_dumper: 32-reg and 4-reg instances,
// scoreboarded byte stream with a falling-edge register file model.
module tb_regfile_debug_dumper;

  logic        clk;
  logic        rst;
  logic        start    [2];
  logic        tx_ready [2];
  logic        busy     [2];
  logic        done     [2];
  logic        dbg_on   [2];
  logic        tx_valid [2];
  logic [4:0]  dbg_addr [2];
  logic [31:0] dbg_data [2];
  logic [7:0]  tx_data  [2];

  logic [31:0] mem [32];
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  int errors = 0;
  int checks = 0;
  int busy_cyc [2];
  int done_cnt [2];
  int done_at  [2];
  int nbytes   [2];
  logic        stall [2];
  logic [7:0]  hold  [2];

  regfile_debug_dumper #(.NUM_REGS(32), .HEADER(8'hA5)) u_dut (
    .clk(clk), .rst(rst), .start(start[0]),
    .busy(busy[0]), .done(done[0]), .dbg_on(dbg_on[0]),
    .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0])
  );

  regfile_debug_dumper #(.NUM_REGS(4), .HEADER(8'hA5)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[1]),
    .busy(busy[1]), .done(done[1]), .dbg_on(dbg_on[1]),
    .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nregs(input int d);
    return (d == 0) ? 32 : 4;
  endfunction

  function automatic logic [31:0] pop(input int d);
    if (d == 0) begin
      if (q0.size() == 0) return 32'hFFFF;
      return {24'h0, q0.pop_front()};
    end
    if (q1.size() == 0) return 32'hFFFF;
    return {24'h0, q1.pop_front()};
  endfunction

  task automatic push(input int d, input logic [7:0] b);
    if (d == 0) q0.push_back(b);
    else q1.push_back(b);
  endtask

  task automatic push_frame(input int d);
    push(d, 8'hA5);
    for (int r = 0; r < nregs(d); r++)
      for (int b = 3; b >= 0; b--)
        push(d, 8'(mem[r] >> (8 * b)));
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Register file debug port model: latches on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      dbg_data[d] <= dbg_on[d] ? mem[dbg_addr[d]] : 32'hDEAD_BEEF;
  end

  // Output monitor: byte scoreboard, stall stability, done timing.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stall[d] = 1'b0;
      end else begin
        if (busy[d]) busy_cyc[d]++;
        if (done[d]) begin
          done_cnt[d]++;
          done_at[d] = busy_cyc[d];
        end
        if (busy[d]) chk($sformatf("dbg_on_busy%0d", d), 32'(dbg_on[d]), 1);
        if (stall[d]) begin
          chk($sformatf("hold_valid%0d", d), 32'(tx_valid[d]), 1);
          chk($sformatf("hold_data%0d", d), 32'(tx_data[d]), 32'(hold[d]));
        end
        if (tx_valid[d] && tx_ready[d]) begin
          nbytes[d]++;
          chk($sformatf("byte%0d_%0d", d, nbytes[d]),
              32'(tx_data[d]), pop(d));
        end
        stall[d] = tx_valid[d] && !tx_ready[d];
        hold[d]  = tx_data[d];
      end
    end
  end

  task automatic check_idle(input int d, input string tag);
    chk({tag, "_busy"},  32'(busy[d]), 0);
    chk({tag, "_done"},  32'(done[d]), 0);
    chk({tag, "_dbgon"}, 32'(dbg_on[d]), 0);
    chk({tag, "_addr"},  32'(dbg_addr[d]), 0);
    chk({tag, "_valid"}, 32'(tx_valid[d]), 0);
  endtask

  task automatic clear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
    busy_cyc[d] = 0;
    done_cnt[d] = 0;
    done_at[d]  = 0;
    nbytes[d]   = 0;
  endtask

  // mode 0: ready held high; mode 1: ready high 1 of 3 cycles.
  task automatic dump(input int d, input int mode, input int again);
    int k;
    clear(d);
    push_frame(d);
    start[d]    = 1'b1;
    tx_ready[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (k = 1; k < 5000 && !(done_cnt[d] > 0 && !busy[d]); k++) begin
      if (mode == 1) tx_ready[d] = (k % 3 == 0);
      start[d] = (k == again);
      @(posedge clk); #1;
    end
    start[d]    = 1'b0;
    tx_ready[d] = 1'b1;
    chk("timeout", 32'(k < 5000), 1);
    chk("done_count", done_cnt[d], 1);
    chk("byte_count", nbytes[d], 1 + 4 * nregs(d));
    chk("queue_left", qsize(d), 0);
    if (mode == 0) chk("done_cycle", done_at[d], 2 + 7 * nregs(d));
    if (mode == 0) chk("busy_cycles", busy_cyc[d], 2 + 7 * nregs(d));
    check_idle(d, "post_done");
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", 32'(busy[d]), 0);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 32; i++)
      mem[i] = {8'(i), 8'(i * 7 + 1), 8'hC0 ^ 8'(i), 8'(255 - i)};
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      tx_ready[d] = 1'b0;
      stall[d] = 1'b0;
    end
    clear(0);
    clear(1);
    rst = 1'b1;
    #2;
    check_idle(0, "reset");
    chk("reset_data", 32'(tx_data[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_idle(0, "idle");
    end

    dump(0, 0, 0);
    dump(0, 1, 0);
    dump(0, 0, 50);
    dump(0, 0, 225);

    // Abandon a dump while byte 2 of reg 5 is on the stream.
    clear(0);
    push_frame(0);
    start[0] = 1'b1;
    tx_ready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (k = 0; k < 500 && !(nbytes[0] == 22 && tx_valid[0]); k++) begin
      @(posedge clk); #1;
    end
    chk("mid_timeout", 32'(k < 500), 1);
    chk("mid_byte", 32'(tx_data[0]), 32'(mem[5][23:16]));
    rst = 1'b1;
    #1;
    check_idle(0, "mid_reset");
    chk("mid_reset_data", 32'(tx_data[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_no_done", done_cnt[0], 0);
    @(posedge clk); #1;
    dump(0, 0, 0);

    dump(1, 0, 0);
    dump(1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
